// File: rtl/teclado_pkg.sv
// Shared types and defaults for the keypad capture block.
// The state encoding is shared by the debounce FSM and the bench.
package teclado_pkg;

    localparam int KEY_WIDTH        = 5;
    localparam int DEBOUNCE_DEFAULT = 4;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        CANDIDATO  = 2'd1,
        PRESIONADA = 2'd2
    } estado_t;

endpackage

// File: rtl/teclado_fifo.sv
// Synchronous first-word-fall-through FIFO for debounced key codes.
// A push into a full FIFO is dropped unless a pop frees a slot on the same edge.
module teclado_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           dato_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dato_o,
    output logic                       vacio_o,
    output logic                       lleno_o,
    output logic [$clog2(DEPTH+1)-1:0] nivel_o,
    output logic                       desborde_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [LW-1:0]    nivel_q;
    logic             desborde_q;
    logic             do_pop;
    logic             do_push;

    assign vacio_o    = (nivel_q == '0);
    assign lleno_o    = (nivel_q == LW'(DEPTH));
    assign nivel_o    = nivel_q;
    assign desborde_o = desborde_q;
    assign dato_o     = mem_q[rd_q];

    assign do_pop  = pop_i & ~vacio_o;
    assign do_push = push_i & (~lleno_o | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q       <= '0;
            rd_q       <= '0;
            nivel_q    <= '0;
            desborde_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= dato_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                nivel_q <= nivel_q + LW'(1);
            end else if (do_pop && !do_push) begin
                nivel_q <= nivel_q - LW'(1);
            end
            if (push_i && !do_push) begin
                desborde_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/teclado_capturador.sv
// Keypad capture: debounces teclas/valido, detects presses with optional
// auto-repeat, and queues accepted codes in a FWFT FIFO.
module teclado_capturador
    import teclado_pkg::*;
#(
    parameter int WIDTH         = KEY_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DEPTH         = 8,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           teclas,
    input  logic                       valido,
    input  logic                       leer,
    output logic [WIDTH-1:0]           dato,
    output logic                       vacio,
    output logic                       lleno,
    output logic [$clog2(DEPTH+1)-1:0] nivel,
    output logic                       desborde,
    output logic                       presionada
);

    localparam int CW = $clog2(STABLE_CYCLES+1);
    localparam int RW = $clog2(REPEAT_CYCLES+2);

    estado_t          st_q, st_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic             push;

    // teclas is only looked at when valido is high, so X never enters cand
    always_comb begin
        st_d   = st_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        push   = 1'b0;
        unique case (st_q)
            REPOSO: begin
                if (valido) begin
                    cand_d = teclas;
                    cnt_d  = CW'(1);
                    st_d   = CANDIDATO;
                end
            end
            CANDIDATO: begin
                if (!valido) begin
                    st_d = REPOSO;
                end else if (teclas != cand_q) begin
                    cand_d = teclas;
                    cnt_d  = CW'(1);
                end else if (cnt_q == CW'(STABLE_CYCLES-1)) begin
                    push  = 1'b1;
                    rep_d = '0;
                    st_d  = PRESIONADA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESIONADA: begin
                if (!valido) begin
                    st_d = REPOSO;
                end else if (teclas != cand_q) begin
                    cand_d = teclas;
                    cnt_d  = CW'(1);
                    st_d   = CANDIDATO;
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_q == RW'(REPEAT_CYCLES-1)) begin
                        push  = 1'b1;
                        rep_d = '0;
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
                end
            end
            default: st_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= REPOSO;
            cand_q <= '0;
            cnt_q  <= '0;
            rep_q  <= '0;
        end else begin
            st_q   <= st_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            rep_q  <= rep_d;
        end
    end

    assign presionada = (st_q == PRESIONADA);

    teclado_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .dato_i     (cand_q),
        .pop_i      (leer),
        .dato_o     (dato),
        .vacio_o    (vacio),
        .lleno_o    (lleno),
        .nivel_o    (nivel),
        .desborde_o (desborde)
    );

endmodule

// File: tb/tb_teclado_capturador.sv
// Scoreboard bench: stimulus queues expected codes, a negedge monitor
// compares every popped FIFO head against the queue.
module tb_teclado_capturador;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] teclas;
    logic       valido;
    logic       leer;
    logic [4:0] dato;
    logic       vacio;
    logic       lleno;
    logic [3:0] nivel;
    logic       desborde;
    logic       presionada;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    teclado_capturador #(
        .WIDTH         (5),
        .STABLE_CYCLES (4),
        .DEPTH         (8),
        .REPEAT_CYCLES (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .teclas     (teclas),
        .valido     (valido),
        .leer       (leer),
        .dato       (dato),
        .vacio      (vacio),
        .lleno      (lleno),
        .nivel      (nivel),
        .desborde   (desborde),
        .presionada (presionada)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Apply inputs now (just after an edge) and let n sampling edges pass.
    task automatic hold(input logic v, input logic [4:0] k,
                        input logic l, input int n);
        valido = v;
        teclas = k;
        leer   = l;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && leer && !vacio) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop: got %0h, expected no entry", dato);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if (dato !== e) begin
                    n_bad++;
                    $display("FAIL pop: got %0h, expected %0h", dato, e);
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        valido = 1'b0;
        teclas = 5'h00;
        leer   = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            hold(1'($urandom), 5'($urandom), 1'($urandom), 1);
        end
        reset = 1'b0;
        valido = 1'b0;
        leer = 1'b0;
        chk("rst_vacio", int'(vacio), 1);
        chk("rst_nivel", int'(nivel), 0);
        chk("rst_lleno", int'(lleno), 0);
        chk("rst_desborde", int'(desborde), 0);
        chk("rst_presionada", int'(presionada), 0);
        chk("rst_dato", int'(dato), 0);

        // three stable samples are one short of acceptance
        hold(1'b1, 5'h0A, 1'b0, 3);
        hold(1'b0, 5'bx, 1'b0, 2);
        chk("short_vacio", int'(vacio), 1);
        chk("short_nivel", int'(nivel), 0);

        hold(1'b1, 5'h0A, 1'b0, 4);
        exp_q.push_back(5'h0A);
        chk("deb_dato", int'(dato), 'h0A);
        chk("deb_nivel", int'(nivel), 1);
        chk("deb_presionada", int'(presionada), 1);
        hold(1'b0, 5'bx, 1'b1, 1);
        chk("deb_drained", int'(vacio), 1);

        // bounce: 0A,0B then four stable 0A
        hold(1'b0, 5'bx, 1'b0, 2);
        hold(1'b1, 5'h0A, 1'b0, 1);
        hold(1'b1, 5'h0B, 1'b0, 1);
        hold(1'b1, 5'h0A, 1'b0, 3);
        chk("bounce_pre", int'(nivel), 0);
        hold(1'b1, 5'h0A, 1'b0, 1);
        exp_q.push_back(5'h0A);
        chk("bounce_nivel", int'(nivel), 1);
        chk("bounce_dato", int'(dato), 'h0A);
        hold(1'b0, 5'bx, 1'b0, 3);
        chk("bounce_once", int'(nivel), 1);
        hold(1'b0, 5'bx, 1'b1, 1);

        // roll-over without release
        hold(1'b0, 5'bx, 1'b0, 1);
        hold(1'b1, 5'h03, 1'b0, 6);
        exp_q.push_back(5'h03);
        hold(1'b1, 5'h11, 1'b0, 6);
        exp_q.push_back(5'h11);
        chk("roll_nivel", int'(nivel), 2);
        chk("roll_dato", int'(dato), 'h03);
        hold(1'b0, 5'bx, 1'b1, 2);
        chk("roll_vacio", int'(vacio), 1);

        // overflow: nine presses, no reads
        hold(1'b0, 5'bx, 1'b0, 1);
        for (int i = 1; i <= 9; i++) begin
            hold(1'b1, 5'(i), 1'b0, 4);
            if (i <= 8) exp_q.push_back(5'(i));
            if (i == 8) begin
                chk("full_lleno", int'(lleno), 1);
                chk("full_desborde", int'(desborde), 0);
            end
            hold(1'b0, 5'bx, 1'b0, 1);
        end
        chk("ovf_lleno", int'(lleno), 1);
        chk("ovf_nivel", int'(nivel), 8);
        chk("ovf_desborde", int'(desborde), 1);
        chk("ovf_head", int'(dato), 'h01);
        hold(1'b1, 5'h14, 1'b0, 3);
        hold(1'b1, 5'h14, 1'b1, 1);
        exp_q.push_back(5'h14);
        chk("pp_nivel", int'(nivel), 8);
        chk("pp_desborde", int'(desborde), 1);
        chk("pp_head", int'(dato), 'h02);
        hold(1'b0, 5'bx, 1'b0, 1);
        hold(1'b0, 5'bx, 1'b1, 8);
        chk("ovf_drained", int'(vacio), 1);
        chk("ovf_sticky", int'(desborde), 1);

        // auto-repeat every 5 cycles after the initial push
        hold(1'b0, 5'bx, 1'b0, 1);
        hold(1'b1, 5'h1F, 1'b0, 18);
        chk("rep_nivel18", int'(nivel), 3);
        hold(1'b1, 5'h1F, 1'b0, 1);
        chk("rep_nivel19", int'(nivel), 4);
        repeat (4) exp_q.push_back(5'h1F);
        hold(1'b0, 5'bx, 1'b0, 10);
        chk("rep_release", int'(nivel), 4);
        chk("rep_presionada", int'(presionada), 0);
        hold(1'b0, 5'bx, 1'b1, 4);
        hold(1'b0, 5'bx, 1'b0, 2);
        chk("end_vacio", int'(vacio), 1);
        chk("end_scoreboard", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/teclado_capturador.md
Name: teclado_capturador

Overview:
- Synthesizable successor to the behavioural keypad stimulus model. Consumes the same `teclas`/`valido` pair, filters bounce and glitches, and detects key-press events.
- Queues accepted key codes in a first-word-fall-through FIFO for a downstream consumer.
- Generalised in code width, debounce length, queue depth and an optional auto-repeat mode.

Parameters:
- WIDTH, 5, width of the key code.
- STABLE_CYCLES, 4, consecutive identical valid samples required to accept a key. Must be >= 2.
- DEPTH, 8, FIFO entries. Must be a power of two, >= 2.
- REPEAT_CYCLES, 0, auto-repeat interval in cycles while a key is held. 0 disables auto-repeat.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- teclas  in  WIDTH  raw key code; don't-care (may be X) while valido=0.
- valido  in  1  raw key-pressed qualifier.
- leer  in  1  pop request from the consumer.
- dato  out  WIDTH  FIFO head; meaningful only when vacio=0.
- vacio  out  1  FIFO empty.
- lleno  out  1  FIFO full.
- nivel  out  $clog2(DEPTH+1)  current number of stored entries.
- desborde  out  1  sticky flag: a key event was dropped because the FIFO was full.
- presionada  out  1  high while a debounced key is held.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to REPOSO; all counters clear.
  - FIFO pointers clear; nivel=0, vacio=1, lleno=0, desborde=0, presionada=0, dato=0.
  - Reset overrides every other input on the same edge. Reset mid-debounce or mid-hold discards the pending key; no push occurs.
- teclas is never compared, stored or propagated while valido=0, so X on teclas must not reach state.
- State machine (registers: cand[WIDTH], cnt, rep):
  - REPOSO:
    - valido=1: cand<=teclas, cnt<=1, go to CANDIDATO.
    - Otherwise stay.
  - CANDIDATO:
    - valido=0: go to REPOSO (glitch rejected, no push).
    - teclas!=cand: cand<=teclas, cnt<=1, stay.
    - teclas==cand and cnt==STABLE_CYCLES-1: push cand, rep<=0, go to PRESIONADA.
    - Otherwise cnt<=cnt+1.
  - PRESIONADA (presionada=1):
    - valido=0: go to REPOSO (release; nothing pushed).
    - teclas!=cand: cand<=teclas, cnt<=1, go to CANDIDATO (roll-over to a new key without release).
    - REPEAT_CYCLES!=0: rep increments each cycle. On the edge where rep reaches REPEAT_CYCLES-1, push cand again and set rep<=0.
- Latency:
  - The push happens on the STABLE_CYCLES-th consecutive sampling edge of the same valid code, counting the first edge seen in REPOSO.
  - dato, vacio and nivel reflect the push immediately after that edge.
- FIFO (FWFT, pointer width $clog2(DEPTH), pointers wrap naturally):
  - Pop: leer=1 and vacio=0 advances the read pointer. leer while vacio=1 is ignored.
  - Push with lleno=1 and no pop on the same edge: the entry is dropped and desborde<=1. desborde holds until reset.
  - Simultaneous push and pop:
    - When full: legal; nivel stays DEPTH and there is no overflow.
    - When empty: push only, since the pop is ignored.
  - lleno = (nivel==DEPTH); vacio = (nivel==0).
- No combinational path from teclas/valido to any output. The only combinational input influence on outputs is none; all outputs are registered or derived from registers.

Decomposition:
- Shared package `teclado_pkg`:
  - state enum {REPOSO, CANDIDATO, PRESIONADA}, 2-bit encoding;
  - default constants KEY_WIDTH=5, DEBOUNCE_DEFAULT=4.
- One sub-module: `teclado_fifo` (parameters WIDTH, DEPTH), a synchronous FWFT FIFO with push/pop/lleno/vacio/nivel/desborde.
- The debounce FSM stays in the top level.
- Whole block: roughly 150-250 lines.

Test Plan:
- Reset hold: after 3 cycles of reset with random teclas/valido, all outputs read reset values (vacio=1, nivel=0, desborde=0, presionada=0).
- Debounce threshold, STABLE_CYCLES=4:
  - teclas=5'h0A with valido=1 for 3 cycles, then valido=0 -> no push, vacio stays 1.
  - teclas=5'h0A held for 4 cycles -> dato=5'h0A, nivel=1, presionada=1 right after the 4th edge.
- Bounce and X rejection: teclas sequence 0A,0B,0A,0A,0A,0A with valido=1; X on teclas during valido=0 gaps -> exactly one push of 5'h0A, and no X in cand or dato.
- Roll-over: hold 5'h03 for 6 cycles, then 5'h11 for 6 cycles without dropping valido -> FIFO holds 03 then 11. Popping with leer yields 03 and then 11.
- Overflow, DEPTH=8: 9 debounced presses with no leer -> lleno=1, nivel=8, desborde=1, and the 9th code is lost. A 10th press with leer=1 on the push edge -> nivel stays 8, and desborde is still 1 (sticky).
- Auto-repeat, REPEAT_CYCLES=5: hold 5'h1F for 4+15 cycles -> 4 entries (1 initial + 3 repeats) of 5'h1F. After valido=0, no further pushes occur.
